game2048_engine: RTL and testbench

//  2048 game core: holds the 4x4 board, executes slide/merge moves from debounced direction pulses,

---
 rtl/game2048_pkg.sv | 37 +++
 rtl/game2048_line_merge.sv | 53 +++++
 rtl/game2048_engine.sv | 180 ++++++++++++++++++
 tb/tb_game2048_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/game2048_pkg.sv
// rtl/game2048_pkg.sv - shared constants, state/direction encodings and board index helpers
package game2048_pkg;

   localparam int TILE_W  = 12;
   localparam int BOARD_W = 192;

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_WAIT, S_MOVE, S_CHECK, S_SPAWN, S_EVAL, S_DONE
   } state_e;

   typedef enum logic [1:0] {
      DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT
   } dir_e;

   // Cell number from row/column, row 0 top, column 0 left.
   function automatic logic [3:0] idx(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

   // Cell index of element e of line k, element 0 sitting at the edge tiles move toward.
   function automatic logic [3:0] line_idx(input dir_e dir, input logic [1:0] k, input logic [1:0] e);
      case (dir)
         DIR_LEFT:  return idx(k, e);
         DIR_RIGHT: return idx(k, 2'd3 - e);
         DIR_UP:    return idx(e, k);
         default:   return idx(2'd3 - e, k);
      endcase
   endfunction

   // Tile value at cell i; indices past the board read as empty.
   function automatic logic [TILE_W-1:0] tile_at(input logic [BOARD_W-1:0] b, input int i);
      logic [BOARD_W-1:0] s;
      s = b >> (TILE_W * i);
      return s[TILE_W-1:0];
   endfunction

endpackage

// File: rtl/game2048_line_merge.sv
// rtl/game2048_line_merge.sv - combinational slide-and-merge of one 4-tile line
module game2048_line_merge
   import game2048_pkg::*;
(
   input  logic [4*TILE_W-1:0] line_i,
   output logic [4*TILE_W-1:0] line_o,
   output logic                changed_o,
   output logic [15:0]         score_o
);

   // Fifth slot stays empty so the pair compare at the last element needs no guard.
   logic [TILE_W-1:0] cmp [5];
   logic [TILE_W-1:0] res [4];
   logic [TILE_W-1:0] merged;
   logic [2:0]        k;
   logic              skip;

   // Compress nonzero tiles toward element 0, then merge equal neighbours once each.
   always_comb begin
      for (int i = 0; i < 5; i++) cmp[i] = '0;
      for (int i = 0; i < 4; i++) res[i] = '0;
      merged  = '0;
      score_o = '0;
      skip    = 1'b0;
      k       = '0;
      for (int i = 0; i < 4; i++) begin
         if (line_i[i*TILE_W +: TILE_W] != '0) begin
            cmp[k[1:0]] = line_i[i*TILE_W +: TILE_W];
            k = k + 3'd1;
         end
      end
      k = '0;
      for (int i = 0; i < 4; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (cmp[i] != '0) begin
            if (cmp[i] == cmp[i+1]) begin
               merged      = {cmp[i][TILE_W-2:0], 1'b0};
               res[k[1:0]] = merged;
               score_o     = score_o + {4'b0, merged};
               skip        = 1'b1;
            end else begin
               res[k[1:0]] = cmp[i];
            end
            k = k + 3'd1;
         end
      end
      for (int i = 0; i < 4; i++) line_o[i*TILE_W +: TILE_W] = res[i];
   end

   assign changed_o = (line_o != line_i);

endmodule

// File: rtl/game2048_engine.sv
// rtl/game2048_engine.sv - 2048 game core: board state, moves, tile spawn, win/lose detection
module game2048_engine
   import game2048_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter logic [11:0] WIN_VALUE = 12'd2048
) (
   input  logic               board_clk,
   input  logic               reset,
   input  logic               start,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               ld_en,
   input  logic [BOARD_W-1:0] ld_board,
   output logic [BOARD_W-1:0] MatrixCopy,
   output logic               Done,
   output logic               Win,
   output logic               busy,
   output logic [15:0]        score
);

   state_e             state_q;
   dir_e               dir_q;
   logic [1:0]         line_q;
   logic [15:0]        lfsr_q;
   logic [BOARD_W-1:0] board_q, matrix_q;
   logic               done_q, win_q, changed_q, second_q;
   logic [15:0]        score_q;
   logic [3:0]         scan_q, cnt_q;

   logic [3:0]         line_ix [4];
   logic [4*TILE_W-1:0] line_in, line_out;
   logic               line_changed;
   logic [15:0]        line_score;
   logic               has_empty, has_pair, has_win;
   logic               any_btn;
   dir_e               btn_dir;
   logic               lfsr_fb;
   logic [TILE_W-1:0]  spawn_val;

   assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign spawn_val = (lfsr_q[7:4] == 4'd0) ? 12'd4 : 12'd2;
   assign any_btn   = btn_up | btn_down | btn_left | btn_right;
   assign btn_dir   = btn_up ? DIR_UP : btn_down ? DIR_DOWN : btn_left ? DIR_LEFT : DIR_RIGHT;

   // Gather the line currently being processed from the working board.
   always_comb begin
      line_in = '0;
      for (int e = 0; e < 4; e++) begin
         line_ix[e] = line_idx(dir_q, line_q, 2'(e));
         line_in[e*TILE_W +: TILE_W] = tile_at(board_q, int'(line_ix[e]));
      end
   end

   game2048_line_merge u_merge (
      .line_i    (line_in),
      .line_o    (line_out),
      .changed_o (line_changed),
      .score_o   (line_score)
   );

   // Board-wide status used by the end-of-turn evaluation.
   always_comb begin
      has_empty = 1'b0;
      has_pair  = 1'b0;
      has_win   = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (tile_at(board_q, r*4+c) == '0) has_empty = 1'b1;
            if (tile_at(board_q, r*4+c) == WIN_VALUE) has_win = 1'b1;
            if (c < 3 && tile_at(board_q, r*4+c) == tile_at(board_q, r*4+c+1)) has_pair = 1'b1;
            if (r < 3 && tile_at(board_q, r*4+c) == tile_at(board_q, r*4+c+4)) has_pair = 1'b1;
         end
      end
   end

   // Game sequencer; the published board only changes on load or at end of turn.
   always_ff @(posedge board_clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         dir_q     <= DIR_UP;
         line_q    <= '0;
         lfsr_q    <= LFSR_SEED;
         board_q   <= '0;
         matrix_q  <= '0;
         done_q    <= 1'b0;
         win_q     <= 1'b0;
         changed_q <= 1'b0;
         second_q  <= 1'b0;
         score_q   <= '0;
         scan_q    <= '0;
         cnt_q     <= '0;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
         case (state_q)
            S_IDLE, S_WAIT, S_DONE: begin
               if (start) begin
                  state_q <= S_INIT;
               end else if (ld_en) begin
                  board_q  <= ld_board;
                  matrix_q <= ld_board;
                  done_q   <= 1'b0;
                  win_q    <= 1'b0;
                  state_q  <= S_WAIT;
               end else if (state_q == S_WAIT && any_btn) begin
                  dir_q     <= btn_dir;
                  line_q    <= '0;
                  changed_q <= 1'b0;
                  state_q   <= S_MOVE;
               end
            end
            S_INIT: begin
               board_q  <= '0;
               score_q  <= '0;
               done_q   <= 1'b0;
               win_q    <= 1'b0;
               second_q <= 1'b1;
               scan_q   <= lfsr_q[3:0];
               cnt_q    <= '0;
               state_q  <= S_SPAWN;
            end
            S_MOVE: begin
               for (int e = 0; e < 4; e++)
                  board_q[int'(line_ix[e])*TILE_W +: TILE_W] <= line_out[e*TILE_W +: TILE_W];
               score_q   <= score_q + line_score;
               changed_q <= changed_q | line_changed;
               line_q    <= line_q + 2'd1;
               if (line_q == 2'd3) state_q <= S_CHECK;
            end
            S_CHECK: begin
               if (changed_q) begin
                  second_q <= 1'b0;
                  scan_q   <= lfsr_q[3:0];
                  cnt_q    <= '0;
                  state_q  <= S_SPAWN;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_SPAWN: begin
               if (tile_at(board_q, int'(scan_q)) == '0) begin
                  board_q[int'(scan_q)*TILE_W +: TILE_W] <= spawn_val;
                  if (second_q) begin
                     second_q <= 1'b0;
                     scan_q   <= lfsr_q[3:0];
                     cnt_q    <= '0;
                  end else begin
                     state_q <= S_EVAL;
                  end
               end else if (cnt_q == 4'd15) begin
                  state_q <= S_EVAL;
               end else begin
                  scan_q <= scan_q + 4'd1;
                  cnt_q  <= cnt_q + 4'd1;
               end
            end
            S_EVAL: begin
               matrix_q <= board_q;
               if (has_win || (!has_empty && !has_pair)) begin
                  done_q  <= 1'b1;
                  win_q   <= has_win;
                  state_q <= S_DONE;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign MatrixCopy = matrix_q;
   assign Done       = done_q;
   assign Win        = win_q;
   assign score      = score_q;
   assign busy       = !(state_q == S_IDLE || state_q == S_WAIT || state_q == S_DONE);

endmodule

// File: tb/tb_game2048_engine.sv
// tb/tb_game2048_engine.sv - scoreboard bench for game2048_engine
module tb_game2048_engine;

   logic         board_clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic         ld_en = 1'b0;
   logic [191:0] ld_board = '0;
   logic [191:0] MatrixCopy;
   logic         Done, Win, busy;
   logic [15:0]  score;

   game2048_engine dut (
      .board_clk (board_clk), .reset (reset), .start (start),
      .btn_up (btn_up), .btn_down (btn_down), .btn_left (btn_left), .btn_right (btn_right),
      .ld_en (ld_en), .ld_board (ld_board),
      .MatrixCopy (MatrixCopy), .Done (Done), .Win (Win), .busy (busy), .score (score)
   );

   always #5 board_clk = ~board_clk;

   typedef struct {
      string        name;
      logic [191:0] board;
      int           spawn_n;
      logic [15:0]  score;
      logic         done;
      logic         win;
   } exp_t;

   exp_t exp_q [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   function automatic logic [191:0] pack(input int v[16]);
      logic [191:0] b;
      b = '0;
      for (int i = 0; i < 16; i++) b[i*12 +: 12] = 12'(v[i]);
      return b;
   endfunction

   task automatic push(input string nm, input logic [191:0] b, input int sp,
                       input logic [15:0] sc, input logic d, input logic w);
      exp_t e;
      e.name = nm; e.board = b; e.spawn_n = sp; e.score = sc; e.done = d; e.win = w;
      exp_q.push_back(e);
   endtask

   // Monitor: a turn result is presented when busy falls.
   logic busy_prev = 1'b0;
   always @(negedge board_clk) begin
      if (busy_prev && !busy) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: busy fell with empty scoreboard");
         end else begin
            exp_t e;
            logic ok_fixed, bad_val;
            int   nsp;
            logic [11:0] v, x;
            e = exp_q.pop_front();
            ok_fixed = 1'b1; bad_val = 1'b0; nsp = 0;
            for (int i = 0; i < 16; i++) begin
               v = MatrixCopy[i*12 +: 12];
               x = e.board[i*12 +: 12];
               if (x != 12'd0) begin
                  if (v != x) ok_fixed = 1'b0;
               end else if (v != 12'd0) begin
                  nsp++;
                  if (v != 12'd2 && v != 12'd4) bad_val = 1'b1;
               end
            end
            if (!ok_fixed) $display("  %s board got %0h", e.name, MatrixCopy);
            chk({e.name, "_board"}, 192'(ok_fixed), 192'(1));
            chk({e.name, "_spawn_cnt"}, 192'(nsp), 192'(e.spawn_n));
            chk({e.name, "_spawn_val"}, 192'(bad_val), 192'(0));
            chk({e.name, "_score"}, 192'(score), 192'(e.score));
            chk({e.name, "_done"}, 192'(Done), 192'(e.done));
            chk({e.name, "_win"}, 192'(Win), 192'(e.win));
         end
      end
      busy_prev = busy;
   end

   task automatic load(input logic [191:0] b);
      @(negedge board_clk);
      ld_board = b; ld_en = 1'b1;
      @(negedge board_clk);
      ld_en = 1'b0;
   endtask

   // m = {start, up, down, left, right}
   task automatic press(input logic [4:0] m);
      @(negedge board_clk);
      {start, btn_up, btn_down, btn_left, btn_right} = m;
      @(negedge board_clk);
      {start, btn_up, btn_down, btn_left, btn_right} = 5'b0;
   endtask

   task automatic wait_idle(input string nm, output int hi);
      hi = 0;
      for (int n = 0; n < 200 && busy; n++) begin
         hi++;
         @(negedge board_clk);
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: busy still high after 200 cycles", nm);
      end
      @(negedge board_clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v[16];
      int hi;
      logic [191:0] lose_b;

      #1;
      chk("rst_matrix", MatrixCopy, '0);
      chk("rst_done", 192'(Done), 192'(0));
      chk("rst_win", 192'(Win), 192'(0));
      chk("rst_busy", 192'(busy), 192'(0));
      chk("rst_score", 192'(score), 192'(0));
      repeat (2) @(negedge board_clk);
      reset = 1'b1;

      // row0 [2,2,2,2] left -> [4,4,0,0]
      v = '{2,2,2,2, 0,0,0,0, 0,0,0,0, 0,0,0,0};
      load(pack(v));
      chk("ld_publish", MatrixCopy, pack(v));
      v = '{4,4,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
      push("left_2222", pack(v), 1, 16'd8, 1'b0, 1'b0);
      press(5'b00010);
      wait_idle("left_2222", hi);

      // row0 [2,2,4,0] left -> [4,4,0,0]
      v = '{2,2,4,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
      load(pack(v));
      v = '{4,4,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
      push("left_2240", pack(v), 1, 16'd12, 1'b0, 1'b0);
      press(5'b00010);
      wait_idle("left_2240", hi);

      // row0 [4,0,4,8] right -> [0,0,8,8]
      v = '{4,0,4,8, 0,0,0,0, 0,0,0,0, 0,0,0,0};
      load(pack(v));
      v = '{0,0,8,8, 0,0,0,0, 0,0,0,0, 0,0,0,0};
      push("right_4048", pack(v), 1, 16'd20, 1'b0, 1'b0);
      press(5'b00001);
      wait_idle("right_4048", hi);

      // full board without pairs: left and up change nothing, back to WAIT after 5 busy cycles
      v = '{2,4,8,16, 4,8,16,2, 2,4,8,16, 4,8,16,2};
      lose_b = pack(v);
      load(lose_b);
      push("nochange_left", lose_b, 0, 16'd20, 1'b0, 1'b0);
      press(5'b00010);
      wait_idle("nochange_left", hi);
      chk("nochange_left_latency", 192'(hi), 192'(5));
      push("nochange_up", lose_b, 0, 16'd20, 1'b0, 1'b0);
      press(5'b01000);
      wait_idle("nochange_up", hi);
      chk("nochange_up_latency", 192'(hi), 192'(5));

      // col0 [1024,1024,0,0] up -> 2048, win
      v = '{1024,0,0,0, 1024,0,0,0, 0,0,0,0, 0,0,0,0};
      load(pack(v));
      v = '{2048,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
      push("win_up", pack(v), 1, 16'd2068, 1'b1, 1'b1);
      press(5'b01000);
      wait_idle("win_up", hi);
      press(5'b00010);
      hi = 0;
      for (int n = 0; n < 8; n++) begin
         if (busy) hi++;
         @(negedge board_clk);
      end
      chk("done_ignores_move", 192'(hi), 192'(0));
      chk("done_held", 192'(Done), 192'(1));

      // up+left together: only up runs
      v = '{2,4,8,16, 2,0,0,0, 0,0,0,0, 0,0,0,0};
      load(pack(v));
      chk("ld_clears_done", 192'(Done), 192'(0));
      v = '{4,4,8,16, 0,0,0,0, 0,0,0,0, 0,0,0,0};
      push("up_over_left", pack(v), 1, 16'd2072, 1'b0, 1'b0);
      press(5'b01010);
      wait_idle("up_over_left", hi);

      // reset during MOVE cycle 2
      v = '{2,2,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
      load(pack(v));
      push("mid_reset", '0, 0, 16'd0, 1'b0, 1'b0);
      press(5'b00010);
      @(negedge board_clk);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_matrix", MatrixCopy, '0);
      chk("async_rst_score", 192'(score), 192'(0));
      repeat (3) @(negedge board_clk);
      reset = 1'b1;

      // new game from IDLE: two tiles, score 0
      push("start", '0, 2, 16'd0, 1'b0, 1'b0);
      press(5'b10000);
      wait_idle("start", hi);

      repeat (2) @(negedge board_clk);
      chk("scoreboard_drained", 192'(exp_q.size()), 192'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
